// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller: FSM state encoding and
// SCON serial-mode encodings.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_LISTEN   = 2'd1,
    ST_SELECTED = 2'd2,
    ST_PASS     = 2'd3
  } rx_state_e;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

endpackage

// File: rtl/uart_addr_match.sv
// Combinational slave-address compare. With UART_AUTO_ADDR_EN defined it
// implements given + broadcast matching; otherwise every address matches.
module uart_addr_match (
  input  logic [7:0] rx_data,
  input  logic [7:0] saddr,
  input  logic [7:0] saden,
  output logic       match
);

`ifdef UART_AUTO_ADDR_EN
  logic       given_match;
  logic       bcast_match;
  logic [7:0] bcast_mask;

  assign given_match = ((rx_data & saden) == (saddr & saden));
  // Broadcast: every bit set in saddr|saden must also be set in the frame.
  assign bcast_mask  = saddr | saden;
  assign bcast_match = ((rx_data & bcast_mask) == bcast_mask);
  assign match       = given_match | bcast_match;
`else
  logic unused_addr_inputs;

  assign unused_addr_inputs = ^{rx_data, saddr, saden};
  assign match              = 1'b1;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: SM2 multiprocessor filter FSM, SBUF/RB8 capture and
// RI/overrun flags. Optional macro: UART_AUTO_ADDR_EN (automatic addressing).
module uart_rx_ctrl
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       ren,
  input  logic       sm2,
  input  logic [7:0] saddr,
  input  logic [7:0] saden,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rb8_in,
  input  logic       ri_clr,
  input  logic       ovr_clr,
  output logic       rx_en,
  output logic [7:0] sbuf,
  output logic       rb8,
  output logic       ri,
  output logic       ovr,
  output logic       selected,
  output logic [1:0] state_dbg
);

  // Interface: rx_done is a one-cycle strobe qualifying rx_data/rb8_in;
  // there is no back-pressure, so a frame arriving while ri is still set is
  // dropped and flagged as overrun. ri_clr/ovr_clr are one-cycle CPU strobes.

  rx_state_e state_q, state_d;
  logic      addr_match;
  logic      frame_pass;
  logic      take_frame;
  logic      addr_mode;

  assign rx_en     = ren;
  assign addr_mode = (mode == MODE2) || (mode == MODE3);

  uart_addr_match u_addr_match (
    .rx_data (rx_data),
    .saddr   (saddr),
    .saden   (saden),
    .match   (addr_match)
  );

  always_comb begin
    frame_pass = 1'b0;
    if (state_q == ST_PASS || !sm2 || mode == MODE0) begin
      frame_pass = 1'b1;
    end else if (mode == MODE1) begin
      frame_pass = rb8_in;
    end else if (state_q == ST_LISTEN) begin
      frame_pass = rb8_in & addr_match;
    end else if (state_q == ST_SELECTED) begin
      frame_pass = !rb8_in || addr_match;
    end
  end

  assign take_frame = rx_done && ren && (state_q != ST_OFF) && frame_pass;

  always_comb begin
    state_d = state_q;
    if (!ren) begin
      state_d = ST_OFF;
    end else if (!sm2) begin
      state_d = ST_PASS;
    end else if (state_q == ST_OFF || state_q == ST_PASS) begin
      state_d = ST_LISTEN;
    end else if (rx_done && addr_mode && rb8_in) begin
      state_d = addr_match ? ST_SELECTED : ST_LISTEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // In OFF the whole register file holds, including the CPU clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf <= 8'h00;
      rb8  <= 1'b0;
      ri   <= 1'b0;
      ovr  <= 1'b0;
    end else if (state_q != ST_OFF) begin
      if (take_frame) begin
        if (ri && !ri_clr) begin
          ovr <= 1'b1;
        end else begin
          sbuf <= rx_data;
          rb8  <= rb8_in;
          ri   <= 1'b1;
          if (ovr_clr) ovr <= 1'b0;
        end
      end else begin
        if (ri_clr)  ri  <= 1'b0;
        if (ovr_clr) ovr <= 1'b0;
      end
    end
  end

  assign selected  = (state_q == ST_SELECTED);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

`ifdef UART_AUTO_ADDR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       ren = 1'b0;
  logic       sm2 = 1'b0;
  logic [7:0] saddr = 8'h00;
  logic [7:0] saden = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rb8_in = 1'b0;
  logic       ri_clr = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       rx_en;
  logic [7:0] sbuf;
  logic       rb8;
  logic       ri;
  logic       ovr;
  logic       selected;
  logic [1:0] state_dbg;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  uart_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ren(ren), .sm2(sm2),
    .saddr(saddr), .saden(saden), .rx_done(rx_done), .rx_data(rx_data),
    .rb8_in(rb8_in), .ri_clr(ri_clr), .ovr_clr(ovr_clr), .rx_en(rx_en),
    .sbuf(sbuf), .rb8(rb8), .ri(ri), .ovr(ovr), .selected(selected),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model
  rx_state_e  m_st;
  logic [7:0] m_sbuf;
  logic       m_rb8, m_ri, m_ovr;

  function automatic bit addr_ok(input logic [7:0] d, input logic [7:0] a, input logic [7:0] m);
    bit given, bcast;
    if (!AUTO) return 1'b1;
    given = 1'b1;
    bcast = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && (d[i] != a[i])) given = 1'b0;
      if ((a[i] || m[i]) && !d[i]) bcast = 1'b0;
    end
    return given || bcast;
  endfunction

  function automatic bit passes(input rx_state_e st);
    bit hit;
    hit = addr_ok(rx_data, saddr, saden);
    if (st == ST_OFF || !ren) return 1'b0;
    if (st == ST_PASS || !sm2 || mode == 2'd0) return 1'b1;
    if (mode == 2'd1) return rb8_in;
    if (st == ST_LISTEN) return rb8_in && hit;
    return !rb8_in || hit;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = ST_OFF; m_sbuf = 8'h00; m_rb8 = 1'b0; m_ri = 1'b0; m_ovr = 1'b0;
    end else begin
      if (m_st != ST_OFF) begin
        if (rx_done && passes(m_st)) begin
          if (m_ri && !ri_clr) m_ovr = 1'b1;
          else begin
            m_sbuf = rx_data; m_rb8 = rb8_in; m_ri = 1'b1;
            if (ovr_clr) m_ovr = 1'b0;
          end
        end else begin
          if (ri_clr) m_ri = 1'b0;
          if (ovr_clr) m_ovr = 1'b0;
        end
      end
      if (!ren) m_st = ST_OFF;
      else if (!sm2) m_st = ST_PASS;
      else if (m_st == ST_OFF || m_st == ST_PASS) m_st = ST_LISTEN;
      else if (rx_done && mode >= 2'd2 && rb8_in)
        m_st = addr_ok(rx_data, saddr, saden) ? ST_SELECTED : ST_LISTEN;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_en", rx_en, ren);
      check("sbuf", sbuf, m_sbuf);
      check("rb8", rb8, m_rb8);
      check("ri", ri, m_ri);
      check("ovr", ovr, m_ovr);
      check("selected", selected, m_st == ST_SELECTED);
      check("state", state_dbg, m_st);
    end
  end

  // driver tasks
  task automatic frame(input logic [7:0] d, input logic b, input logic clr);
    @(posedge clk); #1;
    rx_data = d; rb8_in = b; ri_clr = clr; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; ri_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr(input logic c_ri, input logic c_ovr);
    @(posedge clk); #1;
    ri_clr = c_ri; ovr_clr = c_ovr;
    @(posedge clk); #1;
    ri_clr = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_sbuf", sbuf, 8'h00);
    check("rst_ri", ri, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_selected", selected, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // address frame selects the slave
    mode = 2'd3; ren = 1'b1; sm2 = 1'b1; saddr = 8'h12; saden = 8'hFF;
    idle(2);
    frame(8'h12, 1'b1, 1'b0);
    check("d1_sbuf", sbuf, 8'h12);
    check("d1_rb8", rb8, 1'b1);
    check("d1_ri", ri, 1'b1);
    check("d1_selected", selected, 1'b1);
    check("d1_model_sbuf", m_sbuf, 8'h12);

    // data frame while selected, then foreign address
    pulse_clr(1'b1, 1'b0);
    check("d2_ri_clr", ri, 1'b0);
    frame(8'h55, 1'b0, 1'b0);
    check("d2_sbuf", sbuf, 8'h55);
    check("d2_ri", ri, 1'b1);
    check("d2_rb8", rb8, 1'b0);
    frame(8'h34, 1'b1, 1'b0);
    check("d3_selected", selected, !AUTO);
    check("d3_sbuf", sbuf, 8'h55);
    check("d3_ovr", ovr, !AUTO);
    check("d3_model_ovr", m_ovr, !AUTO);

    // broadcast accepted, unmatched address discarded
    pulse_clr(1'b1, 1'b1);
    check("d4_ovr_clr", ovr, 1'b0);
    saddr = 8'h10; saden = 8'hF0;
    frame(8'hFF, 1'b1, 1'b0);
    check("d4_sbuf", sbuf, 8'hFF);
    check("d4_selected", selected, 1'b1);
    pulse_clr(1'b1, 1'b0);
    frame(8'h20, 1'b1, 1'b0);
    check("d5_sbuf", sbuf, AUTO ? 8'hFF : 8'h20);
    check("d5_ri", ri, !AUTO);
    check("d5_selected", selected, !AUTO);

    // overrun in pass-through, then same frame with coincident ri_clr
    sm2 = 1'b0;
    idle(1);
    pulse_clr(1'b1, 1'b0);
    frame(8'h3C, 1'b0, 1'b0);
    check("d6_sbuf", sbuf, 8'h3C);
    frame(8'hA5, 1'b0, 1'b0);
    check("d6_ovr", ovr, 1'b1);
    check("d6_sbuf_hold", sbuf, 8'h3C);
    frame(8'hA5, 1'b0, 1'b1);
    check("d7_sbuf", sbuf, 8'hA5);
    check("d7_ovr", ovr, 1'b1);
    check("d7_ri", ri, 1'b1);
    check("d7_model_sbuf", m_sbuf, 8'hA5);

    // receiver disabled: strobes ignored
    ren = 1'b0;
    idle(1);
    frame(8'h77, 1'b1, 1'b0);
    check("d8_sbuf", sbuf, 8'hA5);
    check("d8_ri", ri, 1'b1);
    check("d8_ovr", ovr, 1'b1);
    check("d8_rx_en", rx_en, 1'b0);

    // asynchronous reset mid-frame
    ren = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = 8'h99;
    #1 rst_n = 1'b0;
    #1;
    check("d9_sbuf", sbuf, 8'h00);
    check("d9_ri", ri, 1'b0);
    check("d9_ovr", ovr, 1'b0);
    check("d9_rb8", rb8, 1'b0);
    check("d9_selected", selected, 1'b0);
    rx_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 49) == 0) ren = 1'b0;
      else if ($urandom_range(0, 9) == 0) ren = 1'b1;
      if ($urandom_range(0, 29) == 0) sm2 = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        saddr = 8'($urandom); saden = 8'($urandom);
      end
      rx_done = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 2))
        0: rx_data = saddr;
        1: rx_data = 8'hFF;
        default: rx_data = 8'($urandom);
      endcase
      rb8_in  = $urandom_range(0, 1);
      ri_clr  = $urandom_range(0, 4) == 0;
      ovr_clr = $urandom_range(0, 9) == 0;
    end
    @(posedge clk); #1;
    rx_done = 1'b0; ri_clr = 1'b0; ovr_clr = 1'b0;
    idle(2);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
